// File: rtl/mips_pkg.sv
// Shared constants and bundle types for the MIPS pipeline.
// Opcode/funct values, ALU encodings and the IF/ID bundle.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } if_id_t;

   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regdst;
      logic       branch;
      logic       jump;
      logic [2:0] aluctl;
   } ctrl_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational reads with writeback
// bypass, one synchronous write, asynchronous active-low clear.
module regfile
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] mem [32];
   logic        wr_ok;

   assign wr_ok = we && (wa != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wa] <= wd;
      end
   end

   // $0 is hardwired; a same-cycle write wins over the stored value
   always_comb begin
      rd1 = mem[ra1];
      if (ra1 == 5'd0) begin
         rd1 = '0;
      end else if (wr_ok && wa == ra1) begin
         rd1 = wd;
      end
   end

   always_comb begin
      rd2 = mem[ra2];
      if (ra2 == 5'd0) begin
         rd2 = '0;
      end else if (wr_ok && wa == ra2) begin
         rd2 = wd;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID register, register file, decoder and
// early beq/j resolution feeding the next PC back to fetch.
module decode_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] InstrF,
   input  logic [31:0] PCPlus4F,
   input  logic        StallD,
   input  logic        ForwardAD,
   input  logic        ForwardBD,
   input  logic [31:0] ALUOutM,
   input  logic        RegWriteW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] ResultW,
   output logic        PCSrcD,
   output logic [31:0] PCBranchD,
   output logic        JumpD,
   output logic [31:0] PCJumpD,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [4:0]  RsD,
   output logic [4:0]  RtD,
   output logic [4:0]  RdD,
   output logic [31:0] SignImmD,
   output logic        RegWriteD,
   output logic        MemtoRegD,
   output logic        MemWriteD,
   output logic        ALUSrcD,
   output logic        RegDstD,
   output logic        BranchD,
   output logic [2:0]  ALUControlD
);

   if_id_t      ifid;
   ctrl_t       ctrl;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        fn_ok;
   logic [2:0]  fn_alu;
   logic [31:0] cmpa;
   logic [31:0] cmpb;
   logic        flush;

   assign InstrD   = ifid.instr;
   assign PCPlus4D = ifid.pcplus4;
   assign op       = InstrD[31:26];
   assign funct    = InstrD[5:0];

   // stall beats flush so a stalled branch re-evaluates next cycle
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         ifid <= '{instr: NOP_INSTR, pcplus4: '0};
      end else if (!StallD) begin
         if (flush) begin
            ifid <= '{instr: NOP_INSTR, pcplus4: '0};
         end else begin
            ifid <= '{instr: InstrF, pcplus4: PCPlus4F};
         end
      end
   end

   always_comb begin
      fn_ok  = 1'b1;
      fn_alu = ALU_AND;
      unique case (1'b1)
         funct == FN_ADD: fn_alu = ALU_ADD;
         funct == FN_SUB: fn_alu = ALU_SUB;
         funct == FN_AND: fn_alu = ALU_AND;
         funct == FN_OR:  fn_alu = ALU_OR;
         funct == FN_SLT: fn_alu = ALU_SLT;
         default:         fn_ok  = 1'b0;
      endcase
   end

   // unknown opcodes and funct codes decode to an all-zero bubble
   always_comb begin
      ctrl = '0;
      unique case (1'b1)
         op == OP_RTYPE: begin
            if (fn_ok) begin
               ctrl.regwrite = 1'b1;
               ctrl.regdst   = 1'b1;
               ctrl.aluctl   = fn_alu;
            end
         end
         op == OP_LW: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.aluctl   = ALU_ADD;
         end
         op == OP_SW: begin
            ctrl.memwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluctl   = ALU_ADD;
         end
         op == OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.aluctl = ALU_SUB;
         end
         op == OP_ADDI: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.aluctl   = ALU_ADD;
         end
         op == OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   regfile u_rf (
      .clk   (clk),
      .rst_n (Reset),
      .ra1   (InstrD[25:21]),
      .ra2   (InstrD[20:16]),
      .rd1   (RD1D),
      .rd2   (RD2D),
      .we    (RegWriteW),
      .wa    (WriteRegW),
      .wd    (ResultW)
   );

   assign RsD      = InstrD[25:21];
   assign RtD      = InstrD[20:16];
   assign RdD      = InstrD[15:11];
   assign SignImmD = sext16(InstrD[15:0]);

   assign cmpa = ForwardAD ? ALUOutM : RD1D;
   assign cmpb = ForwardBD ? ALUOutM : RD2D;

   assign PCSrcD    = ctrl.branch & (cmpa == cmpb) & ~StallD;
   assign PCBranchD = PCPlus4D + {SignImmD[29:0], 2'b00};
   assign JumpD     = ctrl.jump & ~StallD;
   assign PCJumpD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};
   assign flush     = PCSrcD | JumpD;

   assign RegWriteD   = ctrl.regwrite;
   assign MemtoRegD   = ctrl.memtoreg;
   assign MemWriteD   = ctrl.memwrite;
   assign ALUSrcD     = ctrl.alusrc;
   assign RegDstD     = ctrl.regdst;
   assign BranchD     = ctrl.branch;
   assign ALUControlD = ctrl.aluctl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and random checks of decode_stage against a
// behavioural model of the IF/ID register and register file.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        Reset;
   logic [31:0] InstrF;
   logic [31:0] PCPlus4F;
   logic        StallD;
   logic        ForwardAD;
   logic        ForwardBD;
   logic [31:0] ALUOutM;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        JumpD;
   logic [31:0] PCJumpD;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic [4:0]  RdD;
   logic [31:0] SignImmD;
   logic        RegWriteD;
   logic        MemtoRegD;
   logic        MemWriteD;
   logic        ALUSrcD;
   logic        RegDstD;
   logic        BranchD;
   logic [2:0]  ALUControlD;

   int passed = 0;
   int total  = 0;
   int nfail  = 0;

   logic [31:0] mrf [32];
   logic [31:0] m_instr;
   logic [31:0] m_pc4;

   decode_stage dut (
      .clk         (clk),
      .Reset       (Reset),
      .InstrF      (InstrF),
      .PCPlus4F    (PCPlus4F),
      .StallD      (StallD),
      .ForwardAD   (ForwardAD),
      .ForwardBD   (ForwardBD),
      .ALUOutM     (ALUOutM),
      .RegWriteW   (RegWriteW),
      .WriteRegW   (WriteRegW),
      .ResultW     (ResultW),
      .PCSrcD      (PCSrcD),
      .PCBranchD   (PCBranchD),
      .JumpD       (JumpD),
      .PCJumpD     (PCJumpD),
      .RD1D        (RD1D),
      .RD2D        (RD2D),
      .RsD         (RsD),
      .RtD         (RtD),
      .RdD         (RdD),
      .SignImmD    (SignImmD),
      .RegWriteD   (RegWriteD),
      .MemtoRegD   (MemtoRegD),
      .MemWriteD   (MemWriteD),
      .ALUSrcD     (ALUSrcD),
      .RegDstD     (RegDstD),
      .BranchD     (BranchD),
      .ALUControlD (ALUControlD)
   );

   always #5 clk = ~clk;

   // {regwrite,memtoreg,memwrite,alusrc,regdst,branch,alu[2:0]}
   function automatic logic [8:0] ref_ctrl(input logic [31:0] ins);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         if (fn == 6'h20) return 9'b100010_010;
         if (fn == 6'h22) return 9'b100010_110;
         if (fn == 6'h24) return 9'b100010_000;
         if (fn == 6'h25) return 9'b100010_001;
         if (fn == 6'h2a) return 9'b100010_111;
         return 9'b0;
      end
      if (op == 6'h23) return 9'b110100_010;
      if (op == 6'h2b) return 9'b001100_010;
      if (op == 6'h04) return 9'b000001_110;
      if (op == 6'h08) return 9'b100100_010;
      return 9'b0;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (RegWriteW && WriteRegW == idx) return ResultW;
      return mrf[idx];
   endfunction

   function automatic logic m_br();
      logic [31:0] a;
      logic [31:0] b;
      logic [8:0]  c;
      c = ref_ctrl(m_instr);
      a = ForwardAD ? ALUOutM : mread(m_instr[25:21]);
      b = ForwardBD ? ALUOutM : mread(m_instr[20:16]);
      return c[3] && (a == b) && !StallD;
   endfunction

   function automatic logic m_jmp();
      return (m_instr[31:26] == 6'b000010) && !StallD;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [8:0]  c;
      logic [31:0] simm;
      c    = ref_ctrl(m_instr);
      simm = {{16{m_instr[15]}}, m_instr[15:0]};
      chk({tag, ".ctrl"},
          {23'b0, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
           RegDstD, BranchD, ALUControlD}, {23'b0, c});
      chk({tag, ".rd1"}, RD1D, mread(m_instr[25:21]));
      chk({tag, ".rd2"}, RD2D, mread(m_instr[20:16]));
      chk({tag, ".idx"}, {17'b0, RsD, RtD, RdD},
          {17'b0, m_instr[25:11]});
      chk({tag, ".simm"}, SignImmD, simm);
      chk({tag, ".pcsrc"}, {31'b0, PCSrcD}, {31'b0, m_br()});
      chk({tag, ".pcbr"}, PCBranchD, m_pc4 + simm * 4);
      chk({tag, ".jump"}, {31'b0, JumpD}, {31'b0, m_jmp()});
      chk({tag, ".pcj"}, PCJumpD,
          (m_pc4 & 32'hF000_0000) | ({6'b0, m_instr[25:0]} * 4));
   endtask

   task automatic tick();
      logic fl;
      fl = m_br() || m_jmp();
      @(posedge clk);
      if (!Reset) begin
         model_reset();
      end else begin
         if (RegWriteW && WriteRegW != 5'd0) mrf[WriteRegW] = ResultW;
         if (!StallD) begin
            if (fl) begin
               m_instr = 32'h0;
               m_pc4   = 32'h0;
            end else begin
               m_instr = InstrF;
               m_pc4   = PCPlus4F;
            end
         end
      end
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      InstrF = 0; PCPlus4F = 0; StallD = 0;
      ForwardAD = 0; ForwardBD = 0; ALUOutM = 0;
      RegWriteW = 0; WriteRegW = 0; ResultW = 0;
      #1 Reset = 1'b0;
      model_reset();

      InstrF = 32'h8C220004; PCPlus4F = 32'd8;
      tick(); tick(); #3;
      chk("rst_regwrite", {31'b0, RegWriteD}, 32'd0);
      chk("rst_memtoreg", {31'b0, MemtoRegD}, 32'd0);
      chk("rst_rd1", RD1D, 32'd0);
      chk("rst_pcsrc", {31'b0, PCSrcD}, 32'd0);
      check_all("rst");

      Reset = 1'b1;
      tick(); #3;
      chk("lw_regwrite", {31'b0, RegWriteD}, 32'd1);
      chk("lw_memtoreg", {31'b0, MemtoRegD}, 32'd1);
      chk("lw_alusrc", {31'b0, ALUSrcD}, 32'd1);
      chk("lw_aluctl", {29'b0, ALUControlD}, 32'd2);
      chk("lw_simm", SignImmD, 32'd4);
      chk("lw_rs", {27'b0, RsD}, 32'd1);
      chk("lw_rt", {27'b0, RtD}, 32'd2);
      check_all("lw");

      InstrF = 32'h00602020; PCPlus4F = 32'd12;
      tick();
      RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'hDEADBEEF;
      #3;
      chk("byp_rd1", RD1D, 32'hDEADBEEF);
      chk("byp_rd2", RD2D, 32'd0);
      chk("byp_regdst", {31'b0, RegDstD}, 32'd1);
      check_all("byp");
      tick();
      WriteRegW = 5'd0; ResultW = 32'h12345678;
      #3;
      chk("w0_rd2", RD2D, 32'd0);
      chk("w0_rd1", RD1D, 32'hDEADBEEF);
      check_all("w0");
      WriteRegW = 5'd1; ResultW = 32'd5;
      InstrF = 32'h1022FFFE; PCPlus4F = 32'h100;

      tick();
      RegWriteW = 0; ForwardBD = 1; ALUOutM = 32'd5;
      #3;
      chk("beq_rd1", RD1D, 32'd5);
      chk("beq_pcsrc", {31'b0, PCSrcD}, 32'd1);
      chk("beq_target", PCBranchD, 32'hF8);
      check_all("beq");
      InstrF = 32'h20010007; PCPlus4F = 32'h104;
      tick();
      ForwardBD = 0;
      #3;
      chk("flush_ctrl", {31'b0, RegWriteD}, 32'd0);
      chk("flush_pcbr", PCBranchD, 32'd0);
      check_all("flush");

      InstrF = 32'h1022FFFE; PCPlus4F = 32'h100;
      tick();
      StallD = 1; ForwardBD = 1; ALUOutM = 32'd5;
      #3;
      chk("stall_pcsrc", {31'b0, PCSrcD}, 32'd0);
      chk("stall_branch", {31'b0, BranchD}, 32'd1);
      check_all("stall");
      InstrF = 32'h20010007; PCPlus4F = 32'h104;
      tick();
      StallD = 0;
      #3;
      chk("held_rs", {27'b0, RsD}, 32'd1);
      chk("held_pcsrc", {31'b0, PCSrcD}, 32'd1);
      chk("held_target", PCBranchD, 32'hF8);
      check_all("held");

      InstrF = 32'h08000010; PCPlus4F = 32'hA0000004;
      tick();
      ForwardBD = 0;
      tick(); #3;
      chk("j_jump", {31'b0, JumpD}, 32'd1);
      chk("j_target", PCJumpD, 32'hA0000040);
      check_all("j");
      InstrF = 32'h20010007; PCPlus4F = 32'h108;
      tick(); #3;
      chk("jflush_jump", {31'b0, JumpD}, 32'd0);
      chk("jflush_pcj", PCJumpD, 32'd0);
      check_all("jflush");

      tick();
      RegWriteW = 1; WriteRegW = 5'd1; ResultW = 32'd77;
      tick();
      RegWriteW = 0;
      #3;
      chk("addi_regwrite", {31'b0, RegWriteD}, 32'd1);
      Reset = 1'b0;
      #1;
      model_reset();
      chk("mrst_regwrite", {31'b0, RegWriteD}, 32'd0);
      check_all("mrst");
      Reset = 1'b1;
      InstrF = 32'h00202820; PCPlus4F = 32'h10;
      tick(); #3;
      chk("rel_rs", {27'b0, RsD}, 32'd1);
      chk("rel_rd1", RD1D, 32'd0);
      check_all("rel");

      for (int n = 0; n < 400; n++) begin
         logic [5:0]  op;
         logic [5:0]  fn;
         logic [31:0] ins;
         logic [4:0]  rs;
         logic [4:0]  rt;
         logic [5:0]  fns [5];
         fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
         fns[3] = 6'h25; fns[4] = 6'h2a;
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         ins = $urandom;
         case ($urandom_range(0, 7))
            0: begin
               fn  = fns[$urandom_range(0, 4)];
               ins = {6'h00, rs, rt, ins[15:6], fn};
            end
            1: ins = {6'h00, rs, rt, ins[15:0]};
            2: ins = {6'h23, rs, rt, ins[15:0]};
            3: ins = {6'h2b, rs, rt, ins[15:0]};
            4: ins = {6'h04, rs, rt, ins[15:0]};
            5: ins = {6'h08, rs, rt, ins[15:0]};
            6: begin
               op  = 6'h02;
               ins = {op, ins[25:0]};
            end
            default: ins = ins;
         endcase
         InstrF    = ins;
         PCPlus4F  = $urandom;
         StallD    = ($urandom_range(0, 4) == 0);
         ForwardAD = 1'($urandom_range(0, 1));
         ForwardBD = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1));
         WriteRegW = 5'($urandom_range(0, 7));
         ResultW   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3))
                                                 : $urandom;
         case ($urandom_range(0, 2))
            0: ALUOutM = mread(m_instr[25:21]);
            1: ALUOutM = mread(m_instr[20:16]);
            default: ALUOutM = $urandom;
         endcase
         #3;
         check_all("rnd");
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage MIPS pipeline, directly downstream of fetch. Holds the IF/ID pipeline register, the 32×32 register file and the main/ALU decoder. Resolves `beq` and `j` early in D, returning `PCSrcD`/`PCBranchD` (and the jump target) to fetch. Presents operands, register indices, the sign-extended immediate and control signals to the execute stage.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `InstrF`  in  32  instruction from fetch.
- `PCPlus4F`  in  32  PC+4 from fetch.
- `StallD`  in  1  hold IF/ID contents.
- `ForwardAD`, `ForwardBD`  in  1 each  select `ALUOutM` for the branch comparator A/B operand.
- `ALUOutM`  in  32  memory-stage ALU result.
- `RegWriteW`  in  1  writeback enable.
- `WriteRegW`  in  5  writeback index.
- `ResultW`  in  32  writeback data.
- `PCSrcD`  out  1  branch taken.
- `PCBranchD`  out  32  branch target.
- `JumpD`  out  1  jump taken.
- `PCJumpD`  out  32  jump target.
- `RD1D`, `RD2D`  out  32  register-file read data for rs and rt.
- `RsD`, `RtD`, `RdD`  out  5  `InstrD[25:21]`, `InstrD[20:16]`, `InstrD[15:11]`.
- `SignImmD`  out  32  sign-extended `InstrD[15:0]`.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `ALUSrcD`, `RegDstD`, `BranchD`  out  1 each  control.
- `ALUControlD`  out  3  ALU operation.

## Operation
- **IF/ID register (`InstrD`, `PCPlus4D`)**
  - Async clear to 0 while `Reset`=0.
  - On each edge, priority is:
    1. `StallD`=1: hold.
    2. `PCSrcD | JumpD`: load 0 (flush).
    3. Otherwise: load `InstrF`/`PCPlus4F`.
  - Instruction 0 is the NOP.
- **Decoder**
  - Opcodes:
    - R-type `000000`: RegWrite, RegDst.
    - `lw` `100011`: RegWrite, ALUSrc, MemtoReg, add.
    - `sw` `101011`: MemWrite, ALUSrc, add.
    - `beq` `000100`: Branch, sub.
    - `addi` `001000`: RegWrite, ALUSrc, add.
    - `j` `000010`: jump only.
  - R-type funct to ALUControl: `100000` add=010, `100010` sub=110, `100100` and=000, `100101` or=001, `101010` slt=111.
  - Any other opcode, or R-type with any other funct (including 0): all control outputs 0 and ALUControl=000. Such an instruction is a bubble.
- **Register file**
  - `$0` reads 0 and ignores writes.
  - Write `ResultW` on the edge when `RegWriteW`=1 and `WriteRegW`≠0.
  - Reads are combinational with same-cycle bypass: if `RegWriteW` and `WriteRegW`==read index≠0, return `ResultW`.
  - `Reset`=0 clears all 32 entries.
- **Branch**
  - Operand A = `ForwardAD` ? `ALUOutM` : `RD1D`.
  - Operand B = `ForwardBD` ? `ALUOutM` : `RD2D`.
  - `PCSrcD` = `BranchD` & (A==B) & !`StallD`.
  - `PCBranchD` = `PCPlus4D` + (`SignImmD`<<2), modulo 2^32.
- **Jump**
  - `JumpD` = (opcode==`000010`) & !`StallD`.
  - `PCJumpD` = {`PCPlus4D[31:28]`, `InstrD[25:0]`, 2'b00}.

## Timing
- `InstrF` sampled at edge N appears decoded on all D outputs during cycle N+1. All outputs are combinational from IF/ID state, register-file state and the W/M inputs.
- Outputs under reset: InstrD=0, which gives all controls 0, `PCSrcD`=`JumpD`=0, `PCBranchD`=0, `PCJumpD`=0, `RD1D`=`RD2D`=0.
- Stall and taken branch in the same cycle: stall wins. `PCSrcD`/`JumpD` are forced 0 and IF/ID holds, so the branch re-evaluates next cycle.
- Writeback and read of the same register in the same cycle returns the new value.
- Reset deasserted mid-program: the next edge loads `InstrF` normally.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - ALUControl encodings (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`);
  - `NOP_INSTR`=32'h0.
- One sub-module, `regfile`: 2 combinational read ports with W bypass, 1 synchronous write port, async active-low clear.
- Decoder, comparator, adders and the IF/ID register are inline in `decode_stage`.

## Test plan
- **Reset:** hold `Reset`=0, drive `InstrF`=`8C220004`. Then: all controls 0, `RD1D`=0, `PCSrcD`=0.
- **Load decode:** after reset release, feed `lw $2,4($1)` (`8C220004`), `PCPlus4F`=8. Next cycle: RegWriteD=MemtoRegD=ALUSrcD=1, ALUControlD=010, `SignImmD`=4, `RsD`=1, `RtD`=2.
- **Writeback bypass:** `RegWriteW`=1, `WriteRegW`=3, `ResultW`=`DEADBEEF`, while decoding `add $4,$3,$0`. Then `RD1D`=`DEADBEEF` in the same cycle. Write to `$0` leaves `RD2D`=0.
- **Taken beq with forwarding:** `beq $1,$2,-2` (`1022FFFE`), `PCPlus4D`=`100`, `RD1D`=5, `ALUOutM`=5, `ForwardBD`=1. Then `PCSrcD`=1, `PCBranchD`=`F8`, and IF/ID holds 0 after the edge.
- **Stall over branch:** same as the taken-beq case with `StallD`=1. Then `PCSrcD`=0, `InstrD` unchanged after the edge.
- **Jump:** `j 0x40` (`08000010`), `PCPlus4D`=`A0000004`. Then `JumpD`=1, `PCJumpD`=`A0000040`, next `InstrD`=0.
